// File: rtl/cordic_stage_one_part.sv
// cordic_stage_one_part: halves, squares and converts one IEEE-754 single to signed Q2.20 for the CORDIC core.
// Optional macro STAGE_ONE_SQUARE_RNE_EN: square mantissa rounds to nearest-even instead of truncating.
module cordic_stage_one_part #(
    parameter int FLT_DATA_WIDTH    = 32,
    parameter int CORDIC_DATA_WIDTH = 22
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic                         start,
    input  logic [FLT_DATA_WIDTH-1:0]    x,
    output logic [FLT_DATA_WIDTH-1:0]    half,
    output logic [FLT_DATA_WIDTH-1:0]    square,
    output logic [CORDIC_DATA_WIDTH-1:0] x_to_cordic,
    output logic                         done
);

    localparam int CW = CORDIC_DATA_WIDTH;

`ifdef STAGE_ONE_SQUARE_RNE_EN
    localparam int PROD_LSB = 0;
`else
    localparam int PROD_LSB = 23;
`endif
    localparam int PW = 48 - PROD_LSB;

    // Exponent at which the significand shifted right lands on the Q2.(CW-2) grid.
    localparam logic [8:0]    FX_BIAS = 9'(152 - CW);
    localparam logic [CW-1:0] POS_SAT = {1'b0, {(CW-1){1'b1}}};
    localparam logic [CW-1:0] NEG_SAT = {1'b1, {(CW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t                    state;
    logic [FLT_DATA_WIDTH-1:0] x_reg;
    logic [47:PROD_LSB]        prod;

    logic        x_sign;
    logic [7:0]  x_exp;
    logic [22:0] x_mant;
    logic [23:0] x_sig;
    logic        is_zero;
    logic        is_special;
    logic        is_nan;

    assign x_sign     = x_reg[31];
    assign x_exp      = x_reg[30:23];
    assign x_mant     = x_reg[22:0];
    assign x_sig      = {1'b1, x_mant};
    assign is_zero    = (x_exp == 8'd0);
    assign is_special = (x_exp == 8'hFF);
    assign is_nan     = is_special && (x_mant != 23'd0);

    logic [31:0] half_next;

    always_comb begin
        if (is_special)
            half_next = x_reg;
        else if (x_exp <= 8'd1)
            half_next = {x_sign, 31'd0};
        else
            half_next = {x_sign, x_exp - 8'd1, x_mant};
    end

    logic [22:0] sq_mant_t;
    logic [23:0] sq_round;
    logic [9:0]  sq_exp;
    logic [31:0] square_next;
`ifdef STAGE_ONE_SQUARE_RNE_EN
    logic        sq_guard;
    logic        sq_sticky;
`endif

    // sq_exp carries the +127 bias twice; it is compared against 127 and 382 before rebiasing.
    always_comb begin
        sq_mant_t = prod[47] ? prod[46:24] : prod[45:23];
`ifdef STAGE_ONE_SQUARE_RNE_EN
        if (prod[47]) begin
            sq_guard  = prod[23];
            sq_sticky = |prod[22:0];
        end else begin
            sq_guard  = prod[22];
            sq_sticky = |prod[21:0];
        end
        sq_round = {1'b0, sq_mant_t} + 24'(sq_guard & (sq_sticky | sq_mant_t[0]));
`else
        sq_round = {1'b0, sq_mant_t};
`endif
        sq_exp = {1'b0, x_exp, 1'b0} + 10'(prod[47]) + 10'(sq_round[23]);

        if (is_zero)
            square_next = 32'h0000_0000;
        else if (is_special)
            square_next = is_nan ? 32'h7FC0_0000 : 32'h7F80_0000;
        else if (sq_exp >= 10'd382)
            square_next = 32'h7F80_0000;
        else if (sq_exp <= 10'd127)
            square_next = 32'h0000_0000;
        else
            square_next = {1'b0, 8'(sq_exp - 10'd127), sq_round[22:0]};
    end

    logic [8:0]    fx_shamt;
    logic [23:0]   fx_shifted;
    logic [CW-1:0] fx_mag;
    logic [CW-1:0] fx_next;

    always_comb begin
        fx_shamt   = FX_BIAS - {1'b0, x_exp};
        fx_shifted = x_sig >> fx_shamt;
        fx_mag     = CW'(fx_shifted);
        if (is_nan || is_zero)
            fx_next = '0;
        else if (x_exp >= 8'd128)
            fx_next = x_sign ? NEG_SAT : POS_SAT;
        else
            fx_next = x_sign ? (~fx_mag + 1'b1) : fx_mag;
    end

    // Whole slice advances only on clk_en; outputs are written once per operation in NORM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            x_reg       <= '0;
            prod        <= '0;
            half        <= '0;
            square      <= '0;
            x_to_cordic <= '0;
            done        <= 1'b0;
        end else if (clk_en) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        x_reg <= x;
                        done  <= 1'b0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    prod  <= PW'(({24'd0, x_sig} * {24'd0, x_sig}) >> PROD_LSB);
                    state <= NORM;
                end
                NORM: begin
                    half        <= half_next;
                    square      <= square_next;
                    x_to_cordic <= fx_next;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_stage_one_part.sv
// Scoreboard bench for cordic_stage_one_part: directed corner cases plus randomized operands vs. a numeric model.
module tb_cordic_stage_one_part;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        start;
    logic [31:0] x;
    logic [31:0] half;
    logic [31:0] square;
    logic [21:0] x_to_cordic;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] s;
        logic [21:0] f;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_half = 32'd0;
    logic [31:0] last_square = 32'd0;

    cordic_stage_one_part #(.FLT_DATA_WIDTH(32), .CORDIC_DATA_WIDTH(22)) dut (
        .clk(clk),
        .rst(rst),
        .clk_en(clk_en),
        .start(start),
        .x(x),
        .half(half),
        .square(square),
        .x_to_cordic(x_to_cordic),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] model_half(input logic [31:0] v);
        int e = int'(v[30:23]);
        if (e == 255) return v;
        if (e <= 1)   return {v[31], 31'd0};
        return {v[31], 8'(e - 1), v[22:0]};
    endfunction

    // Exact integer product, normalised by locating its leading one; rounding compares the remainder to half an ulp.
    function automatic logic [31:0] model_square(input logic [31:0] v);
        int          e = int'(v[30:23]);
        logic [63:0] sig, p, m;
        int          msb, sh, be;
        if (e == 0)   return 32'h0000_0000;
        if (e == 255) return (v[22:0] == 23'd0) ? 32'h7F80_0000 : 32'h7FC0_0000;
        sig = {40'd0, 1'b1, v[22:0]};
        p   = sig * sig;
        msb = 63;
        while (!p[msb]) msb--;
        sh  = msb - 23;
        m   = p >> sh;
        be  = 2 * e - 127 + (msb - 46);
`ifdef STAGE_ONE_SQUARE_RNE_EN
        begin
            logic [63:0] rem, halfway;
            rem     = p & ((64'd1 << sh) - 64'd1);
            halfway = 64'd1 << (sh - 1);
            if (rem > halfway || (rem == halfway && m[0])) m = m + 64'd1;
            if (m == (64'd1 << 24)) begin
                m  = m >> 1;
                be = be + 1;
            end
        end
`endif
        if (be >= 255) return 32'h7F80_0000;
        if (be <= 0)   return 32'h0000_0000;
        return {1'b0, be[7:0], m[22:0]};
    endfunction

    function automatic logic [21:0] model_fx(input logic [31:0] v);
        int  e = int'(v[30:23]);
        real mag;
        int  imag;
        if (e == 255 && v[22:0] != 23'd0) return 22'd0;
        if (e == 0) return 22'd0;
        mag = real'({1'b1, v[22:0]}) * (2.0 ** (e - 130));
        if (mag >= 2097152.0) return v[31] ? 22'h200000 : 22'h1FFFFF;
        imag = $rtoi(mag);
        return v[31] ? 22'(-imag) : 22'(imag);
    endfunction

    // Accepts one operand, checks done timing and output hold, and queues the expected results.
    task automatic applyStimulus(input logic [31:0] xv, input logic [31:0] eh,
                                 input logic [31:0] es, input logic [21:0] ef);
        exp_t e;
        e.h = eh;
        e.s = es;
        e.f = ef;
        @(negedge clk);
        x     = xv;
        start = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        x     = $urandom;
        checkOutput("done_fall", {31'd0, done}, 32'd0);
        checkOutput("hold_half", half, last_half);
        checkOutput("hold_square", square, last_square);
        @(posedge clk); #1;
        checkOutput("done_mul", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        checkOutput("done_rise", {31'd0, done}, 32'd1);
        last_half   = eh;
        last_square = es;
    endtask

    task automatic applyRandom(input logic [31:0] xv);
        applyStimulus(xv, model_half(xv), model_square(xv), model_fx(xv));
    endtask

    // Monitor: one scoreboard entry per rising edge of done.
    initial begin
        logic done_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_underflow: got unexpected result, expected none");
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("half", half, e.h);
                    checkOutput("square", square, e.s);
                    checkOutput("x_to_cordic", {10'd0, x_to_cordic}, {10'd0, e.f});
                end
            end
            done_prev = done;
        end
    end

    logic [31:0] specials [10] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                   32'h7FC0_1234, 32'h0000_0001, 32'h00FF_FFFF, 32'h7F7F_FFFF,
                                   32'h3FFF_FFFF, 32'hC000_0000};

    initial begin
        logic [31:0] rx;
        rst    = 1'b0;
        clk_en = 1'b1;
        start  = 1'b0;
        x      = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_half", half, 32'd0);
        checkOutput("rst_square", square, 32'd0);
        checkOutput("rst_fx", {10'd0, x_to_cordic}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(32'h3F80_0000, 32'h3F00_0000, 32'h3F80_0000, 22'h100000);
        applyStimulus(32'hBF00_0000, 32'hBE80_0000, 32'h3E80_0000, 22'h380000);
        applyStimulus(32'h4040_0000, 32'h3FC0_0000, 32'h4110_0000, 22'h1FFFFF);
`ifdef STAGE_ONE_SQUARE_RNE_EN
        applyStimulus(32'h3FC0_0001, 32'h3F40_0001, 32'h4010_0002, 22'h180000);
`else
        applyStimulus(32'h3FC0_0001, 32'h3F40_0001, 32'h4010_0001, 22'h180000);
`endif
        applyStimulus(32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 22'h000000);
        applyStimulus(32'hC0A0_0000, 32'hC020_0000, 32'h41C8_0000, 22'h200000);

        for (int i = 0; i < 48; i++) begin
            case ($urandom_range(0, 3))
                0: rx = $urandom;
                1: rx = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
                2: rx = specials[$urandom_range(0, 9)];
                default: rx = {1'($urandom),
                               ($urandom_range(0, 1) == 1) ? 8'($urandom_range(60, 66))
                                                           : 8'($urandom_range(188, 194)),
                               23'($urandom)};
            endcase
            applyRandom(rx);
        end

        // Stall in MUL: five frozen edges push done out by exactly five cycles.
        begin
            exp_t e;
            e.h = 32'h3F00_0000;
            e.s = 32'h3F80_0000;
            e.f = 22'h100000;
            @(negedge clk);
            x     = 32'h3F80_0000;
            start = 1'b1;
            sb_q.push_back(e);
            @(posedge clk); #1;
            start  = 1'b0;
            clk_en = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                checkOutput("stall_done", {31'd0, done}, 32'd0);
            end
            clk_en = 1'b1;
            @(posedge clk); #1;
            checkOutput("stall_norm", {31'd0, done}, 32'd0);
            @(posedge clk); #1;
            checkOutput("stall_rise", {31'd0, done}, 32'd1);
        end

        // Reset while in NORM clears everything immediately and the aborted result never appears.
        @(negedge clk);
        x     = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_half", half, 32'd0);
        checkOutput("abort_square", square, 32'd0);
        checkOutput("abort_fx", {10'd0, x_to_cordic}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("idle_after_abort", {31'd0, done}, 32'd0);
        last_half   = 32'd0;
        last_square = 32'd0;

        applyStimulus(32'h3F80_0000, 32'h3F00_0000, 32'h3F80_0000, 22'h100000);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_stage_one_part.md
# cordic_stage_one_part

Front-end preprocessing slice for the final-adder CORDIC path. It accepts one IEEE-754 single-precision operand and produces three results:
- the operand halved (float),
- the operand squared (float),
- the operand converted to the 22-bit fixed-point format consumed by the CORDIC core.

The parent stage instantiates two copies side by side. It waits for both `done` flags, then clears the slices through reset.

## Interface
Parameters:
- FLT_DATA_WIDTH, 32, float operand/result width (only 32 supported)
- CORDIC_DATA_WIDTH, 22, fixed-point output width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- clk_en  in  1  global advance enable; when 0 all state and outputs freeze
- start  in  1  request; sampled only in IDLE/DONE with clk_en=1
- x  in  32  IEEE-754 single operand
- half  out  32  x/2, float
- square  out  32  x*x, float
- x_to_cordic  out  22  x as signed two's-complement Q2.20
- done  out  1  level; results valid while high

## Operation
- States: IDLE, MUL, NORM, DONE.
- IDLE or DONE, with start=1 and clk_en=1:
  - capture x;
  - clear done;
  - go to MUL.
- MUL:
  - unpack x;
  - form the 48-bit product of the 24-bit significands (hidden bit restored);
  - go to NORM.
- NORM:
  - normalise and round the product;
  - compute half and the fixed-point value;
  - register all three outputs;
  - set done=1;
  - go to DONE.
- DONE:
  - hold outputs and done until rst or a new accepted start.
- start in MUL/NORM is ignored. x is only sampled at acceptance.

Arithmetic rules:
- Denormal inputs are flushed to zero: exp=0 is treated as ±0.
- half:
  - ±0 gives ±0;
  - Inf/NaN pass through unchanged;
  - exp=1 gives signed zero;
  - otherwise exp−1, with sign and mantissa unchanged.
- square:
  - sign is always 0;
  - zero input gives 0x00000000;
  - Inf input gives 0x7F800000;
  - NaN input gives 0x7FC00000;
  - biased exponent = 2e−127, plus 1 if the product is ≥2;
  - exponent ≥255 saturates to +Inf;
  - exponent ≤0 flushes to +0;
  - mantissa rounding per Configuration.
- x_to_cordic:
  - value is x·2^20, truncated toward zero, then negated if the sign is set;
  - |x| ≥ 2 saturates to 0x1FFFFF (positive) or 0x200000 (negative);
  - NaN gives 0;
  - ±Inf saturates.

## Timing
- Reset values: done=0, half=0, square=0, x_to_cordic=0; state=IDLE.
- Reset mid-operation aborts immediately; the captured operand is discarded.
- Latency is counted in clk_en-qualified edges:
  - edge 0 accepts start;
  - edge 2 registers the outputs and raises done.
  - With clk_en held at 1, done is high 3 cycles after the accept edge's cycle begins.
- clk_en low stalls the pipeline in place. Each stalled cycle adds exactly one cycle of latency.
- Restart from DONE:
  - done falls on the accept edge;
  - outputs keep their old values until the new NORM edge overwrites them.
- start and rst assertion together: reset wins.

## Configuration
- STAGE_ONE_SQUARE_RNE_EN:
  - defined: square mantissa uses round-to-nearest-even (guard/round/sticky from the discarded product bits); a rounding carry into bit 24 renormalises, with exponent+1.
  - undefined: square mantissa is truncated toward zero; no rounding logic is built.
- half and x_to_cordic are unaffected by this macro.

## Test plan
- x=0x3F800000 (1.0), clk_en=1: half=0x3F000000, square=0x3F800000, x_to_cordic=0x100000, done high 3 cycles after start.
- x=0xBF000000 (−0.5): half=0xBE800000, square=0x3E800000, x_to_cordic=0x380000.
- x=0x40400000 (3.0): half=0x3FC00000, square=0x41100000, x_to_cordic=0x1FFFFF (saturated).
- x=0x3FC00001:
  - with STAGE_ONE_SQUARE_RNE_EN, square=0x40100002;
  - without it, square=0x40100001.
- Denormal x=0x00000001: all outputs 0, done still asserts.
- Stall and reset:
  - clk_en low for 5 cycles during MUL: done is delayed exactly 5 cycles.
  - rst low during NORM: done=0 and outputs=0 immediately, state IDLE.
